// File: rtl/osnt_sume_reg_arbiter.sv
// -----------------------------------------------------------------------------
// osnt_sume_reg_arbiter
//
// Shares one IPIF-style register slave port between two register-access
// requesters (Req0 = host AXI-Lite IPIF, Req1 = internal configuration
// sequencer). Round-robin arbitration, one outstanding access at a time, and
// a per-access timeout that completes the access with an error if the slave
// never acknowledges.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET : clock, synchronous active-high reset
//   Req{0,1}_CS/RNW/Addr/Data/BE : requester access request (CS held until ack)
//   Req{0,1}_RdData/RdAck/WrAck/Error : requester completion (1-cycle pulses)
//   Bus2IP_CS/RNW/Addr/Data/BE : downstream register slave request
//   IP2Bus_Data/RdAck/WrAck    : downstream register slave response
//   Grant                      : index of current or last granted requester
// -----------------------------------------------------------------------------
module osnt_sume_reg_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_TIMEOUT          = 256,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_ERR_DATA = 32'hDEADBEEF
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,

    input  logic                              Req0_CS,
    input  logic                              Req0_RNW,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     Req0_Addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     Req0_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   Req0_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     Req0_RdData,
    output logic                              Req0_RdAck,
    output logic                              Req0_WrAck,
    output logic                              Req0_Error,

    input  logic                              Req1_CS,
    input  logic                              Req1_RNW,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     Req1_Addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     Req1_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   Req1_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     Req1_RdData,
    output logic                              Req1_RdAck,
    output logic                              Req1_WrAck,
    output logic                              Req1_Error,

    output logic                              Bus2IP_CS,
    output logic                              Bus2IP_RNW,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
    input  logic                              IP2Bus_RdAck,
    input  logic                              IP2Bus_WrAck,

    output logic                              Grant
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int BEW   = C_S_AXI_DATA_WIDTH / 8;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(C_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;        // requester favoured on a tie
    logic              grant_q, grant_d;
    logic              cs_q, cs_d;
    logic              rnw_q, rnw_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [BEW-1:0]    be_q, be_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        rd_ack_q, rd_ack_d;
    logic [1:0]        wr_ack_q, wr_ack_d;
    logic [1:0]        err_q, err_d;
    logic [DW-1:0]     rd_data_q [2];
    logic [DW-1:0]     rd_data_d [2];

    // Requester request lines gathered so the winner can be selected by index.
    logic [1:0]        req_cs;
    logic              win_idx;
    logic              ack_match;
    logic              timeout_hit;

    assign req_cs = {Req1_CS, Req0_CS};

    // With both requesting the pointer decides; otherwise the lone requester.
    always_comb begin
        win_idx = 1'b0;
        if (req_cs == 2'b11) begin
            win_idx = ptr_q;
        end else if (req_cs[1]) begin
            win_idx = 1'b1;
        end
    end

    // Only the ack matching the registered direction completes an access.
    assign ack_match   = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;
    assign timeout_hit = (cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cs_d      = cs_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        rd_ack_d  = 2'b00;
        wr_ack_d  = 2'b00;
        err_d     = 2'b00;
        rd_data_d = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (|req_cs) begin
                    grant_d = win_idx;
                    rnw_d   = win_idx ? Req1_RNW  : Req0_RNW;
                    addr_d  = win_idx ? Req1_Addr : Req0_Addr;
                    data_d  = win_idx ? Req1_Data : Req0_Data;
                    be_d    = win_idx ? Req1_BE   : Req0_BE;
                    cs_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end

            S_ACCESS: begin
                // A real ack takes priority over a coincident timeout.
                if (ack_match || timeout_hit) begin
                    cs_d    = 1'b0;
                    state_d = S_RELEASE;
                    if (rnw_q) begin
                        rd_ack_d[grant_q]  = 1'b1;
                        rd_data_d[grant_q] = ack_match ? IP2Bus_Data : C_ERR_DATA;
                    end else begin
                        wr_ack_d[grant_q]  = 1'b1;
                        rd_data_d[grant_q] = '0;
                    end
                    err_d[grant_q] = ~ack_match;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RELEASE: begin
                // Hold off re-arbitration until the winner drops its request so
                // its stale CS cannot be mistaken for a new access.
                if (!req_cs[grant_q]) begin
                    ptr_d   = ~grant_q;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            grant_q   <= 1'b0;
            cs_q      <= 1'b0;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            cnt_q     <= '0;
            rd_ack_q  <= 2'b00;
            wr_ack_q  <= 2'b00;
            err_q     <= 2'b00;
            rd_data_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cs_q      <= cs_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            cnt_q     <= cnt_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign Bus2IP_CS   = cs_q;
    assign Bus2IP_RNW  = rnw_q;
    assign Bus2IP_Addr = addr_q;
    assign Bus2IP_Data = data_q;
    assign Bus2IP_BE   = be_q;
    assign Grant       = grant_q;

    assign Req0_RdData = rd_data_q[0];
    assign Req0_RdAck  = rd_ack_q[0];
    assign Req0_WrAck  = wr_ack_q[0];
    assign Req0_Error  = err_q[0];
    assign Req1_RdData = rd_data_q[1];
    assign Req1_RdAck  = rd_ack_q[1];
    assign Req1_WrAck  = wr_ack_q[1];
    assign Req1_Error  = err_q[1];

endmodule

// File: doc/osnt_sume_reg_arbiter.md
Name: osnt_sume_reg_arbiter

Overview:
- Shares one IPIF-style register slave port (Bus2IP_*/IP2Bus_*) between two register-access requesters: host AXI-Lite IPIF and an internal configuration sequencer.
- Fair round-robin arbitration, one outstanding access at a time.
- Per-access timeout returns an error when the slave never acknowledges.
- Sits between sume_axi_ipif / sequencer and the register bank of an OSNT core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width of all data buses.
- C_S_AXI_ADDR_WIDTH, 32, address width.
- C_TIMEOUT, 256, cycles in ACCESS without ack before error completion; valid range 2..65535.
- C_ERR_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- Req{0,1}_CS  in  1  access request; held high until this requester's ack, then dropped.
- Req{0,1}_RNW  in  1  1=read, 0=write.
- Req{0,1}_Addr  in  C_S_AXI_ADDR_WIDTH  address.
- Req{0,1}_Data  in  C_S_AXI_DATA_WIDTH  write data.
- Req{0,1}_BE  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- Req{0,1}_RdData  out  C_S_AXI_DATA_WIDTH  read data, valid with RdAck.
- Req{0,1}_RdAck  out  1  one-cycle read completion pulse.
- Req{0,1}_WrAck  out  1  one-cycle write completion pulse.
- Req{0,1}_Error  out  1  high with the ack pulse on timeout.
- Bus2IP_CS, Bus2IP_RNW  out  1  downstream select / direction.
- Bus2IP_Addr  out  C_S_AXI_ADDR_WIDTH  downstream address.
- Bus2IP_Data  out  C_S_AXI_DATA_WIDTH  downstream write data.
- Bus2IP_BE  out  C_S_AXI_DATA_WIDTH/8  downstream byte enables.
- IP2Bus_Data  in  C_S_AXI_DATA_WIDTH  slave read data.
- IP2Bus_RdAck, IP2Bus_WrAck  in  1  slave acks.
- Grant  out  1  index of the current or last granted requester (status).

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer favours Req0, timeout counter 0.
- Mid-operation reset: the access is abandoned, with no ack to either requester. Bus2IP_CS is 0 in the cycle after reset is sampled.
- State IDLE
  - If any Req_CS is high, grant one requester.
  - Single requester: that one is granted.
  - Both: the requester the pointer favours.
  - On grant, register RNW/Addr/Data/BE from the winner and go to ACCESS. Bus2IP_CS rises the cycle after Req_CS is first sampled.
- State ACCESS
  - Bus2IP_* are held stable from registers; input changes are ignored.
  - Timeout counter increments each cycle, starting at 0 on entry.
  - Matching ack: IP2Bus_RdAck when RNW=1, IP2Bus_WrAck when RNW=0.
  - Non-matching ack is ignored.
  - On matching ack:
    - Next cycle, pulse the winner's RdAck/WrAck for 1 cycle.
    - RdData = captured IP2Bus_Data for reads; 0 for writes.
    - Error = 0.
    - Bus2IP_CS drops in that same cycle.
    - Go to RELEASE.
  - On counter == C_TIMEOUT-1 with no matching ack:
    - Complete identically, except Error = 1 and RdData = C_ERR_DATA for reads.
    - Ack and timeout in the same cycle: ack wins, Error = 0.
- State RELEASE
  - Wait for the winner's Req_CS = 0, then go to IDLE.
  - Move the pointer to favour the other requester.
  - Minimum gap between consecutive Bus2IP_CS pulses is 2 idle cycles.
- Single-access latency: Req_CS high at cycle t, slave ack at cycle t+1+k, requester ack at t+2+k.
- The loser's Req_CS stays pending; it is granted on the next IDLE at latest. No starvation: with both always requesting, grants strictly alternate.
- Req_RdData holds its last value between acks.
- At most one Req ack pulse per cycle, and never to the non-granted requester.

Test Plan:
- Req0 write, Addr=0x10, Data=0xA5A5A5A5, slave WrAck 3 cycles after Bus2IP_CS -> Bus2IP_Addr=0x10 and Data=0xA5A5A5A5 stable throughout; Req0_WrAck 1-cycle pulse; Error=0; Req1 outputs stay 0.
- Req0 and Req1 raise reads in the same cycle after reset, slave returns 0x11 then 0x22 -> Req0 served first with RdData=0x11; after release, Req1 gets 0x22; Grant = 0 then 1.
- Both requesters re-request continuously for 6 accesses -> Grant sequence alternates 0,1,0,1,0,1.
- Req1 read, slave never acks, C_TIMEOUT=16 -> Req1_RdAck with Error=1 and RdData=0xDEADBEEF exactly 17 cycles after Req1_CS; Bus2IP_CS is low next cycle.
- Read in progress, slave asserts WrAck, then RdAck 2 cycles later -> WrAck ignored; completion only on RdAck with Error=0.
- S_AXI_ARESET asserted during ACCESS -> no Req ack; Bus2IP_CS=0 next cycle; after release, a new Req1-only request is granted normally.
